rx_cmd_parser: RTL and testbench
================================

RX_CMD_PARSER -- requirements
Module: rx_cmd_parser

Interface
REQ-001 Parameter DATA_W, default 8, operand width in bits; SHALL be a multiple of 4 in the range 8..32.
REQ-002 Parameter OP_W, default 6, ALU opcode width in bits.
REQ-003 Parameter DEPTH, default 4, command FIFO depth; SHALL be a power of 2 and at least 2.
REQ-004 clk  input  1  system clock; all logic is on the rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; reset==0 sampled on a clk edge resets the block.
REQ-006 rx_done_tick  input  1  one-cycle strobe; rx_data is valid in that cycle.
REQ-007 rx_data  input  8  received ASCII byte.
REQ-008 rd  input  1  pops the head command when cmd_empty==0.
REQ-009 a  output  DATA_W  operand A of the head command.
REQ-010 b  output  DATA_W  operand B of the head command.
REQ-011 op  output  OP_W  opcode of the head command.
REQ-012 cmd_empty  output  1  FIFO holds no command.
REQ-013 cmd_full  output  1  FIFO holds DEPTH commands.
REQ-014 err_tick  output  1  one-cycle pulse on a syntax error or a dropped command.

Function
REQ-015 Frame format: hexA ',' hexB ',' opchar CR (0x0D); a space (0x20) SHALL be ignored in every state.
REQ-016 FSM states: S_A, S_B, S_OP, S_END, S_ERR; the FSM advances only on cycles where rx_done_tick==1.
REQ-017 S_A/S_B hex digit handling: digits 0-9, a-f and A-F are accepted; acc <= {acc[DATA_W-5:0], nibble}; digit count is tracked per field.
REQ-018 S_A/S_B ',' handling: ',' with 1..DATA_W/4 digits latches the field and moves to S_B or S_OP respectively.
REQ-019 Opchar mapping: '+'=100000, '-'=100010, '&'=100100, '|'=100101, '^'=100110, '~'=100111, '>'=000011, '<'=000010; a valid opchar moves the FSM to S_END.
REQ-020 S_END: CR pushes {A,B,op} into the FIFO and returns the FSM to S_A with accumulators and digit counts cleared.
REQ-021 Errors: any of the following SHALL pulse err_tick in the next cycle and move the FSM to S_ERR.
- empty field
- more than DATA_W/4 digits in a field
- illegal character
- non-CR byte in S_END
- CR before S_END
REQ-022 S_ERR discards bytes until CR, then returns to S_A; a CR that causes an error SHALL return directly to S_A.
REQ-023 Push when cmd_full==1 and rd==0: the command is dropped and err_tick pulses; the FSM still returns to S_A.
REQ-024 Push and pop in the same cycle: both SHALL occur, including when the FIFO is full; the count is unchanged.
REQ-025 rd when cmd_empty==1 SHALL be ignored.
REQ-026 a, b and op SHALL show the head entry, first-word fall-through; they are 0 when cmd_empty==1.
REQ-027 Latency: cmd_empty SHALL deassert on the first clk edge after the edge that samples the CR strobe, i.e. 1 cycle.
REQ-028 a and b carry raw two's-complement bits; no sign extension or range check is performed.

Reset
REQ-029 On reset==0, the following SHALL be cleared:
- FSM to S_A
- accumulators and digit counts to 0
- FIFO pointers and count to 0
- cmd_empty=1, cmd_full=0, err_tick=0, a=b=op=0
REQ-030 Reset mid-frame SHALL discard the partial frame; the next complete frame SHALL parse normally.

Structure
REQ-031 Shared package rx_cmd_pkg SHALL hold:
- ASCII constants (CR, comma, space)
- opcode constants
- FSM state encoding
REQ-032 Sub-module cmd_fifo SHALL be parametrised by width (2*DATA_W+OP_W) and DEPTH, and SHALL own the pointers, count, cmd_full and cmd_empty.
REQ-033 The parser SHALL contain only the FSM, accumulators, opchar decode and error logic.

Verification (DATA_W=8, DEPTH=4)
REQ-034 Frame "5F,10,+\r" -> one cycle after the CR tick: cmd_empty=0, a=8'h5F, b=8'h10, op=6'b100000.
REQ-035 Frame "1A2,3,+\r" -> err_tick pulse, nothing pushed; then "3,4,-\r" -> a=3, b=4, op=6'b100010.
REQ-036 Five valid frames with rd=0 -> cmd_full=1 after the 4th; the 5th is dropped with an err_tick pulse; rd pops the 4 commands in order.
REQ-037 With the FIFO full, rd=1 in the same cycle as a CR push -> cmd_full stays 1; the new command becomes the tail.
REQ-038 "ff,Ff,~\r" -> a=8'hFF, b=8'hFF, op=6'b100111.
REQ-039 Sequence "5F," then reset low for 1 cycle, then "2,2,&\r" -> cmd_empty=1 during reset; afterwards a=2, b=2, op=6'b100100.

Source files
------------

// File: rtl/rx_cmd_pkg.sv
// ---------------------------------------------------------------------------
// rx_cmd_pkg
// Shared definitions for the ASCII command parser: character constants,
// ALU opcode constants, parser FSM state encoding and the two character
// classification helpers (hex digit and opchar decode).
// ---------------------------------------------------------------------------
package rx_cmd_pkg;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_COMMA = 8'h2C;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    localparam int OPC_W = 6;

    localparam logic [OPC_W-1:0] OPC_ADD = 6'b100000;
    localparam logic [OPC_W-1:0] OPC_SUB = 6'b100010;
    localparam logic [OPC_W-1:0] OPC_AND = 6'b100100;
    localparam logic [OPC_W-1:0] OPC_OR  = 6'b100101;
    localparam logic [OPC_W-1:0] OPC_XOR = 6'b100110;
    localparam logic [OPC_W-1:0] OPC_NOR = 6'b100111;
    localparam logic [OPC_W-1:0] OPC_SRL = 6'b000011;
    localparam logic [OPC_W-1:0] OPC_SLL = 6'b000010;

    typedef enum logic [2:0] {
        S_A   = 3'd0,
        S_B   = 3'd1,
        S_OP  = 3'd2,
        S_END = 3'd3,
        S_ERR = 3'd4
    } state_t;

    // Returns {valid, nibble}; letters of either case map to 10..15.
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        logic [4:0] r;
        r = 5'd0;
        if (c >= 8'h30 && c <= 8'h39) begin
            r = {1'b1, c[3:0]};
        end else if ((c >= 8'h61 && c <= 8'h66) || (c >= 8'h41 && c <= 8'h46)) begin
            // 'a'/'A' have low nibble 1, so +9 gives 10
            r = {1'b1, c[3:0] + 4'd9};
        end else begin
            r = 5'd0;
        end
        return r;
    endfunction

    // Returns {valid, opcode}.
    function automatic logic [OPC_W:0] op_decode(input logic [7:0] c);
        logic [OPC_W:0] r;
        case (c)
            8'h2B:   r = {1'b1, OPC_ADD};  // '+'
            8'h2D:   r = {1'b1, OPC_SUB};  // '-'
            8'h26:   r = {1'b1, OPC_AND};  // '&'
            8'h7C:   r = {1'b1, OPC_OR};   // '|'
            8'h5E:   r = {1'b1, OPC_XOR};  // '^'
            8'h7E:   r = {1'b1, OPC_NOR};  // '~'
            8'h3E:   r = {1'b1, OPC_SRL};  // '>'
            8'h3C:   r = {1'b1, OPC_SLL};  // '<'
            default: r = {(OPC_W+1){1'b0}};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rx_cmd_parser_if.sv
// ---------------------------------------------------------------------------
// rx_cmd_parser_if
// Bundles the byte input strobe, the command-pop handshake and the head
// command / status outputs of rx_cmd_parser.
//   master : drives rx_done_tick, rx_data, rd; observes the rest
//   slave  : the parser side (rx_cmd_parser)
// ---------------------------------------------------------------------------
interface rx_cmd_parser_if #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 6
) ();
    logic              rx_done_tick;
    logic [7:0]        rx_data;
    logic              rd;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
    logic              cmd_empty;
    logic              cmd_full;
    logic              err_tick;

    modport master (
        output rx_done_tick, rx_data, rd,
        input  a, b, op, cmd_empty, cmd_full, err_tick
    );

    modport slave (
        input  rx_done_tick, rx_data, rd,
        output a, b, op, cmd_empty, cmd_full, err_tick
    );
endinterface

// File: rtl/cmd_fifo.sv
// ---------------------------------------------------------------------------
// cmd_fifo
// First-word fall-through command FIFO. The head entry is visible on o_data
// (forced to zero while empty). A push into a full FIFO is accepted only if
// a pop happens in the same cycle; otherwise it is dropped and o_drop is
// raised for that cycle. A pop on an empty FIFO is ignored.
// Ports:
//   i_clk, i_reset (sync, active low), i_push/i_data, i_pop,
//   o_data (head), o_empty, o_full, o_drop
// ---------------------------------------------------------------------------
module cmd_fifo #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_drop
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (r_count == CNT_W'(0));
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_pop  = i_pop & ~o_empty;
    // A full FIFO still takes the push when the head leaves in the same cycle
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_drop    = i_push & o_full & ~i_pop;
    assign o_data    = o_empty ? {WIDTH{1'b0}} : r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage write; contents need no reset because o_data is masked when empty
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/rx_cmd_parser.sv
// ---------------------------------------------------------------------------
// rx_cmd_parser
// Parses ASCII frames "hexA,hexB,opchar<CR>" arriving one byte per
// rx_done_tick, and queues {A,B,op} commands in a FWFT FIFO. Spaces are
// ignored everywhere. Syntax errors and commands dropped on a full FIFO
// give a one-cycle err_tick.
// Ports:
//   clk, reset (sync, active low)
//   bus.rx_done_tick/rx_data : received byte strobe
//   bus.rd                   : pop head command
//   bus.a/b/op               : head command (0 when empty)
//   bus.cmd_empty/cmd_full   : FIFO status
//   bus.err_tick             : error pulse
// ---------------------------------------------------------------------------
module rx_cmd_parser
    import rx_cmd_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OP_W   = 6,
    parameter int DEPTH  = 4
) (
    input  logic          clk,
    input  logic          reset,
    rx_cmd_parser_if.slave bus
);
    localparam int NIB    = DATA_W / 4;
    localparam int CNT_W  = $clog2(NIB + 1);
    localparam int FIFO_W = 2 * DATA_W + OP_W;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_acc_a;
    logic [DATA_W-1:0] r_acc_b;
    logic [DATA_W-1:0] w_acc_a_nxt;
    logic [DATA_W-1:0] w_acc_b_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [OPC_W-1:0]  r_op;
    logic [OPC_W-1:0]  w_op_nxt;
    logic              w_frame_clear;
    logic              w_syntax_err;
    logic              w_push_req;
    logic [4:0]        w_hex;
    logic [OPC_W:0]    w_opc;

    logic              r_push;
    logic [FIFO_W-1:0] r_push_data;
    logic              r_err_tick;
    logic              w_drop;
    logic [FIFO_W-1:0] w_head;
    logic              w_empty;
    logic              w_full;

    assign w_hex = hex_decode(bus.rx_data);
    assign w_opc = op_decode(bus.rx_data);

    // FSM next-state, field accumulation and error detection
    always_comb begin
        w_state_nxt   = r_state;
        w_acc_a_nxt   = r_acc_a;
        w_acc_b_nxt   = r_acc_b;
        w_cnt_nxt     = r_cnt;
        w_op_nxt      = r_op;
        w_frame_clear = 1'b0;
        w_syntax_err  = 1'b0;
        w_push_req    = 1'b0;

        if (!bus.rx_done_tick || bus.rx_data == ASCII_SPACE) begin
            w_state_nxt = r_state;
        end else begin
            case (r_state)
                S_A, S_B: begin
                    if (w_hex[4]) begin
                        if (r_cnt == CNT_W'(NIB)) begin
                            // field already holds the maximum digit count
                            w_syntax_err = 1'b1;
                            w_state_nxt  = S_ERR;
                        end else if (r_state == S_A) begin
                            w_acc_a_nxt = {r_acc_a[DATA_W-5:0], w_hex[3:0]};
                            w_cnt_nxt   = r_cnt + CNT_W'(1);
                        end else begin
                            w_acc_b_nxt = {r_acc_b[DATA_W-5:0], w_hex[3:0]};
                            w_cnt_nxt   = r_cnt + CNT_W'(1);
                        end
                    end else if (bus.rx_data == ASCII_COMMA) begin
                        if (r_cnt == CNT_W'(0)) begin
                            w_syntax_err = 1'b1;
                            w_state_nxt  = S_ERR;
                        end else begin
                            w_cnt_nxt   = CNT_W'(0);
                            w_state_nxt = (r_state == S_A) ? S_B : S_OP;
                        end
                    end else if (bus.rx_data == ASCII_CR) begin
                        // the erroring CR also ends the frame
                        w_syntax_err  = 1'b1;
                        w_frame_clear = 1'b1;
                    end else begin
                        w_syntax_err = 1'b1;
                        w_state_nxt  = S_ERR;
                    end
                end
                S_OP: begin
                    if (w_opc[OPC_W]) begin
                        w_op_nxt    = w_opc[OPC_W-1:0];
                        w_state_nxt = S_END;
                    end else if (bus.rx_data == ASCII_CR) begin
                        w_syntax_err  = 1'b1;
                        w_frame_clear = 1'b1;
                    end else begin
                        w_syntax_err = 1'b1;
                        w_state_nxt  = S_ERR;
                    end
                end
                S_END: begin
                    if (bus.rx_data == ASCII_CR) begin
                        w_push_req    = 1'b1;
                        w_frame_clear = 1'b1;
                    end else begin
                        w_syntax_err = 1'b1;
                        w_state_nxt  = S_ERR;
                    end
                end
                S_ERR: begin
                    if (bus.rx_data == ASCII_CR) begin
                        w_frame_clear = 1'b1;
                    end else begin
                        w_state_nxt = S_ERR;
                    end
                end
                default: begin
                    w_frame_clear = 1'b1;
                end
            endcase
        end
    end

    // FSM state, accumulators, digit count and latched opcode
    always_ff @(posedge clk) begin
        if (!reset || w_frame_clear) begin
            r_state <= S_A;
            r_acc_a <= {DATA_W{1'b0}};
            r_acc_b <= {DATA_W{1'b0}};
            r_cnt   <= {CNT_W{1'b0}};
            r_op    <= {OPC_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_acc_a <= w_acc_a_nxt;
            r_acc_b <= w_acc_b_nxt;
            r_cnt   <= w_cnt_nxt;
            r_op    <= w_op_nxt;
        end
    end

    // Registered push request (FIFO sees the command one cycle after CR) and
    // the combined error pulse
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_push      <= 1'b0;
            r_push_data <= {FIFO_W{1'b0}};
            r_err_tick  <= 1'b0;
        end else begin
            r_push      <= w_push_req;
            r_push_data <= {r_acc_a, r_acc_b, OP_W'(r_op)};
            r_err_tick  <= w_syntax_err | w_drop;
        end
    end

    cmd_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .i_clk   (clk),
        .i_reset (reset),
        .i_push  (r_push),
        .i_data  (r_push_data),
        .i_pop   (bus.rd),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_drop  (w_drop)
    );

    assign bus.a         = w_head[FIFO_W-1 -: DATA_W];
    assign bus.b         = w_head[OP_W +: DATA_W];
    assign bus.op        = w_head[OP_W-1:0];
    assign bus.cmd_empty = w_empty;
    assign bus.cmd_full  = w_full;
    assign bus.err_tick  = r_err_tick;

endmodule

// File: tb/tb_rx_cmd_parser.sv
// ---------------------------------------------------------------------------
// tb_rx_cmd_parser
// Self-checking bench for rx_cmd_parser (DATA_W=8, OP_W=6, DEPTH=4).
// Frames are byte queues; a string-level reference parser decides whether a
// frame yields a command or one error pulse and what the command holds.
// ---------------------------------------------------------------------------
module tb_rx_cmd_parser;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] op;
    } cmd_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;
    int   err_seen;

    byte unsigned frame_q[$];
    cmd_t         exp_q[$];
    byte unsigned op_chars [8];

    rx_cmd_parser_if #(.DATA_W(8), .OP_W(6)) bus ();

    rx_cmd_parser #(.DATA_W(8), .OP_W(6), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // error pulse counter, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.err_tick === 1'b1) err_seen = err_seen + 1;
    end

    // ---------------- reference model ----------------
    function automatic int hexval(input byte unsigned c);
        if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
        if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
        if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
        return -1;
    endfunction

    function automatic bit ref_opcode(input byte unsigned c, output logic [5:0] op);
        op = 6'b000000;
        case (c)
            8'h2B: op = 6'b100000;
            8'h2D: op = 6'b100010;
            8'h26: op = 6'b100100;
            8'h7C: op = 6'b100101;
            8'h5E: op = 6'b100110;
            8'h7E: op = 6'b100111;
            8'h3E: op = 6'b000011;
            8'h3C: op = 6'b000010;
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    // body is everything before the terminating CR
    function automatic bit ref_parse(input byte unsigned body[$], output cmd_t c);
        byte unsigned s[$];
        int c1, c2, v, d;
        c.a = 8'h00; c.b = 8'h00; c.op = 6'b000000;
        foreach (body[i]) if (body[i] != 8'h20) s.push_back(body[i]);
        c1 = -1; c2 = -1;
        foreach (s[i]) begin
            if (s[i] == 8'h2C) begin
                if (c1 < 0) c1 = i;
                else if (c2 < 0) c2 = i;
            end
        end
        if (c1 < 1 || c1 > 2 || c2 - c1 < 2 || c2 - c1 > 3 || s.size() != c2 + 2) return 1'b0;
        v = 0;
        for (int i = 0; i < c1; i++) begin
            d = hexval(s[i]);
            if (d < 0) return 1'b0;
            v = v * 16 + d;
        end
        c.a = 8'(v);
        v = 0;
        for (int i = c1 + 1; i < c2; i++) begin
            d = hexval(s[i]);
            if (d < 0) return 1'b0;
            v = v * 16 + d;
        end
        c.b = 8'(v);
        return ref_opcode(s[c2 + 1], c.op);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] c, input int gap);
        bus.rx_data      = c;
        bus.rx_done_tick = 1'b1;
        @(posedge clk); #1;
        bus.rx_done_tick = 1'b0;
        idle(gap);
    endtask

    task automatic pop_one();
        bus.rd = 1'b1;
        @(posedge clk); #1;
        bus.rd = 1'b0;
    endtask

    task automatic send_body(input int max_gap);
        foreach (frame_q[i]) send_byte(frame_q[i], $urandom_range(0, max_gap));
    endtask

    task automatic send_frame(input int max_gap);
        send_body(max_gap);
        send_byte(8'h0D, 0);
        idle(3);
    endtask

    task automatic load_str(input string s);
        frame_q.delete();
        for (int i = 0; i < s.len(); i++) frame_q.push_back(s[i]);
    endtask

    task automatic push_char(input byte unsigned c);
        if ($urandom_range(0, 7) == 0) frame_q.push_back(8'h20);
        frame_q.push_back(c);
    endtask

    function automatic byte unsigned hex_char(input int d, input bit upper);
        if (d < 10) return 8'(48 + d);
        return upper ? 8'(55 + d) : 8'(87 + d);
    endfunction

    task automatic add_digits(input int n);
        for (int i = 0; i < n; i++) push_char(hex_char($urandom_range(0, 15), 1'($urandom_range(0, 1))));
    endtask

    task automatic add_value(input logic [7:0] v);
        if (v > 8'd15 || $urandom_range(0, 1) == 1)
            push_char(hex_char(int'(v[7:4]), 1'($urandom_range(0, 1))));
        push_char(hex_char(int'(v[3:0]), 1'($urandom_range(0, 1))));
    endtask

    task automatic build_valid();
        frame_q.delete();
        add_value(8'($urandom_range(0, 255)));
        push_char(8'h2C);
        add_value(8'($urandom_range(0, 255)));
        push_char(8'h2C);
        push_char(op_chars[$urandom_range(0, 7)]);
    endtask

    task automatic build_random();
        int kind, na, nb;
        kind = $urandom_range(0, 10);
        na = $urandom_range(1, 2);
        nb = $urandom_range(1, 2);
        if (kind == 6) begin
            if ($urandom_range(0, 1) == 1) na = 0; else nb = 0;
        end
        if (kind == 7) begin
            if ($urandom_range(0, 1) == 1) na = 3; else nb = 3;
        end
        frame_q.delete();
        add_digits(na);
        if (kind == 8) push_char(8'h67);
        push_char(8'h2C);
        add_digits(nb);
        if (kind != 10) begin
            push_char(8'h2C);
            push_char(op_chars[$urandom_range(0, 7)]);
            if (kind == 9) push_char(8'h31);
        end
        if ($urandom_range(0, 3) == 0) frame_q.push_back(8'h20);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        idle(2);
        n_checks += 6;
        if (bus.cmd_empty !== 1'b1) $display("FAIL reset_empty got %b want 1", bus.cmd_empty); else n_pass++;
        if (bus.cmd_full !== 1'b0) $display("FAIL reset_full got %b want 0", bus.cmd_full); else n_pass++;
        if (bus.err_tick !== 1'b0) $display("FAIL reset_err got %b want 0", bus.err_tick); else n_pass++;
        if (bus.a !== 8'h00) $display("FAIL reset_a got %h want 00", bus.a); else n_pass++;
        if (bus.b !== 8'h00) $display("FAIL reset_b got %h want 00", bus.b); else n_pass++;
        if (bus.op !== 6'b000000) $display("FAIL reset_op got %b want 000000", bus.op); else n_pass++;
        reset = 1'b1;
        idle(1);
    endtask

    task automatic test_basic_latency();
        load_str("5F,10,+");
        send_body(0);
        send_byte(8'h0D, 0);
        n_checks++;
        if (bus.cmd_empty !== 1'b1) $display("FAIL latency_early got %b want 1", bus.cmd_empty); else n_pass++;
        idle(1);
        n_checks += 4;
        if (bus.cmd_empty !== 1'b0) $display("FAIL latency_empty got %b want 0", bus.cmd_empty); else n_pass++;
        if (bus.a !== 8'h5F) $display("FAIL basic_a got %h want 5f", bus.a); else n_pass++;
        if (bus.b !== 8'h10) $display("FAIL basic_b got %h want 10", bus.b); else n_pass++;
        if (bus.op !== 6'b100000) $display("FAIL basic_op got %b want 100000", bus.op); else n_pass++;
        pop_one();
        n_checks++;
        if (bus.cmd_empty !== 1'b1) $display("FAIL basic_pop_empty got %b want 1", bus.cmd_empty); else n_pass++;
        // pop on empty must not disturb the count
        pop_one();
        n_checks += 2;
        if (bus.cmd_empty !== 1'b1) $display("FAIL rd_on_empty got %b want 1", bus.cmd_empty); else n_pass++;
        if (bus.a !== 8'h00) $display("FAIL empty_a got %h want 00", bus.a); else n_pass++;
    endtask

    task automatic test_long_field();
        int e0;
        e0 = err_seen;
        load_str("1A2,3,+");
        send_frame(1);
        n_checks += 2;
        if (err_seen - e0 !== 1) $display("FAIL long_err got %0d want 1", err_seen - e0); else n_pass++;
        if (bus.cmd_empty !== 1'b1) $display("FAIL long_nopush got %b want 1", bus.cmd_empty); else n_pass++;
        load_str("3,4,-");
        send_frame(1);
        n_checks += 3;
        if (bus.a !== 8'h03) $display("FAIL recover_a got %h want 03", bus.a); else n_pass++;
        if (bus.b !== 8'h04) $display("FAIL recover_b got %h want 04", bus.b); else n_pass++;
        if (bus.op !== 6'b100010) $display("FAIL recover_op got %b want 100010", bus.op); else n_pass++;
        pop_one();
    endtask

    task automatic test_fill_drop();
        cmd_t c;
        int e0;
        exp_q.delete();
        for (int k = 0; k < 5; k++) begin
            build_valid();
            void'(ref_parse(frame_q, c));
            if (k < 4) exp_q.push_back(c);
            e0 = err_seen;
            send_frame(2);
            if (k == 3) begin
                n_checks++;
                if (bus.cmd_full !== 1'b1) $display("FAIL fill_full got %b want 1", bus.cmd_full); else n_pass++;
            end
        end
        n_checks += 2;
        if (err_seen - e0 !== 1) $display("FAIL drop_err got %0d want 1", err_seen - e0); else n_pass++;
        if (bus.cmd_full !== 1'b1) $display("FAIL drop_full got %b want 1", bus.cmd_full); else n_pass++;
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front();
            n_checks += 3;
            if (bus.a !== c.a) $display("FAIL fill_a got %h want %h", bus.a, c.a); else n_pass++;
            if (bus.b !== c.b) $display("FAIL fill_b got %h want %h", bus.b, c.b); else n_pass++;
            if (bus.op !== c.op) $display("FAIL fill_op got %b want %b", bus.op, c.op); else n_pass++;
            pop_one();
        end
        n_checks++;
        if (bus.cmd_empty !== 1'b1) $display("FAIL fill_drained got %b want 1", bus.cmd_empty); else n_pass++;
    endtask

    task automatic test_full_push_pop();
        cmd_t c;
        int e0;
        exp_q.delete();
        for (int k = 0; k < 4; k++) begin
            build_valid();
            void'(ref_parse(frame_q, c));
            exp_q.push_back(c);
            send_frame(0);
        end
        build_valid();
        void'(ref_parse(frame_q, c));
        void'(exp_q.pop_front());
        exp_q.push_back(c);
        e0 = err_seen;
        send_body(0);
        // CR strobe, then rd asserted in the cycle the push lands
        send_byte(8'h0D, 0);
        bus.rd = 1'b1;
        @(posedge clk); #1;
        bus.rd = 1'b0;
        n_checks++;
        if (bus.cmd_full !== 1'b1) $display("FAIL pushpop_full got %b want 1", bus.cmd_full); else n_pass++;
        idle(2);
        n_checks++;
        if (err_seen - e0 !== 0) $display("FAIL pushpop_err got %0d want 0", err_seen - e0); else n_pass++;
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front();
            n_checks += 3;
            if (bus.a !== c.a) $display("FAIL pushpop_a got %h want %h", bus.a, c.a); else n_pass++;
            if (bus.b !== c.b) $display("FAIL pushpop_b got %h want %h", bus.b, c.b); else n_pass++;
            if (bus.op !== c.op) $display("FAIL pushpop_op got %b want %b", bus.op, c.op); else n_pass++;
            pop_one();
        end
    endtask

    task automatic test_hex_case();
        load_str("ff,Ff,~");
        send_frame(0);
        n_checks += 3;
        if (bus.a !== 8'hFF) $display("FAIL case_a got %h want ff", bus.a); else n_pass++;
        if (bus.b !== 8'hFF) $display("FAIL case_b got %h want ff", bus.b); else n_pass++;
        if (bus.op !== 6'b100111) $display("FAIL case_op got %b want 100111", bus.op); else n_pass++;
        pop_one();
    endtask

    task automatic test_reset_midframe();
        load_str("7,7,+");
        send_frame(0);
        load_str("5F,");
        send_body(0);
        reset = 1'b0;
        @(posedge clk); #1;
        n_checks += 2;
        if (bus.cmd_empty !== 1'b1) $display("FAIL midreset_empty got %b want 1", bus.cmd_empty); else n_pass++;
        if (bus.a !== 8'h00) $display("FAIL midreset_a got %h want 00", bus.a); else n_pass++;
        reset = 1'b1;
        load_str("2,2,&");
        send_frame(1);
        n_checks += 3;
        if (bus.a !== 8'h02) $display("FAIL midreset_next_a got %h want 02", bus.a); else n_pass++;
        if (bus.b !== 8'h02) $display("FAIL midreset_next_b got %h want 02", bus.b); else n_pass++;
        if (bus.op !== 6'b100100) $display("FAIL midreset_next_op got %b want 100100", bus.op); else n_pass++;
        pop_one();
    endtask

    task automatic test_random_back_to_back();
        cmd_t c;
        bit   ok;
        int   e0;
        exp_q.delete();
        for (int k = 0; k < 40; k++) begin
            build_random();
            ok = ref_parse(frame_q, c);
            if (ok) exp_q.push_back(c);
            e0 = err_seen;
            send_frame(2);
            n_checks++;
            if (err_seen - e0 !== (ok ? 0 : 1))
                $display("FAIL rand_err frame %0d got %0d want %0d", k, err_seen - e0, ok ? 0 : 1);
            else n_pass++;
            if (exp_q.size() >= $urandom_range(1, 3) || k == 39) begin
                while (exp_q.size() > 0) begin
                    c = exp_q.pop_front();
                    n_checks += 3;
                    if (bus.a !== c.a) $display("FAIL rand_a got %h want %h", bus.a, c.a); else n_pass++;
                    if (bus.b !== c.b) $display("FAIL rand_b got %h want %h", bus.b, c.b); else n_pass++;
                    if (bus.op !== c.op) $display("FAIL rand_op got %b want %b", bus.op, c.op); else n_pass++;
                    pop_one();
                end
                n_checks++;
                if (bus.cmd_empty !== 1'b1) $display("FAIL rand_drained got %b want 1", bus.cmd_empty); else n_pass++;
            end
        end
    endtask

    initial begin
        clk              = 1'b0;
        reset            = 1'b0;
        bus.rx_done_tick = 1'b0;
        bus.rx_data      = 8'h00;
        bus.rd           = 1'b0;
        n_checks         = 0;
        n_pass           = 0;
        err_seen         = 0;
        op_chars = '{8'h2B, 8'h2D, 8'h26, 8'h7C, 8'h5E, 8'h7E, 8'h3E, 8'h3C};

        test_reset();
        test_basic_latency();
        test_long_field();
        test_fill_drop();
        test_full_push_pop();
        test_hex_case();
        test_reset_midframe();
        test_random_back_to_back();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
